// File: rtl/end_screen_ctrl_if.sv
// Video/control bundle between the game-over compositor and its neighbours.
// master drives the pixel/control inputs; slave is the compositor itself.
interface end_screen_ctrl_if;
    logic        video_on;
    logic        frame_tick;
    logic        game_over;
    logic        restart_btn;
    logic [11:0] game_rgb;
    logic [11:0] gameover_rgb;
    logic        gameover_on;
    logic [11:0] rgb_out;
    logic        freeze;
    logic        restart_req;

    modport master (
        output video_on, frame_tick, game_over, restart_btn,
               game_rgb, gameover_rgb, gameover_on,
        input  rgb_out, freeze, restart_req
    );

    modport slave (
        input  video_on, frame_tick, game_over, restart_btn,
               game_rgb, gameover_rgb, gameover_on,
        output rgb_out, freeze, restart_req
    );
endinterface

// File: rtl/end_screen_ctrl.sv
// Game-over sequencer (PLAY/DIM/SHOW) and final 12-bit pixel mux; rgb_out is 1 clk after its inputs.
// No backpressure: free-running video stream. Background dimming in DIM/SHOW enabled by END_SCREEN_DIM_EN.
module end_screen_ctrl #(
    parameter int DIM_FRAMES   = 60,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             clk,
    input  logic             reset,
    end_screen_ctrl_if.slave bus
);
    typedef enum logic [1:0] {PLAY, DIM, SHOW} state_t;

    localparam logic [7:0] DIM_LAST   = 8'(DIM_FRAMES - 1);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    state_t      state, state_nxt;
    logic [7:0]  fcnt, fcnt_nxt;
    logic        blink_vis, blink_vis_nxt;
    logic        go_prev, btn_prev;
    logic        go_rise, btn_rise;
    logic        restart_nxt;
    logic [11:0] bg, rgb_nxt;
    logic [11:0] rgb_q;
    logic        freeze_q, restart_q;

    assign go_rise  = bus.game_over & ~go_prev;
    assign btn_rise = bus.restart_btn & ~btn_prev;

    always_comb begin
        state_nxt     = state;
        fcnt_nxt      = fcnt;
        blink_vis_nxt = blink_vis;
        restart_nxt   = 1'b0;
        case (state)
            PLAY: begin
                if (go_rise) begin
                    state_nxt = DIM;
                    fcnt_nxt  = 8'd0;
                end
            end
            DIM: begin
                if (bus.frame_tick) begin
                    if (fcnt == DIM_LAST) begin
                        state_nxt     = SHOW;
                        fcnt_nxt      = 8'd0;
                        blink_vis_nxt = 1'b1;
                    end else begin
                        fcnt_nxt = fcnt + 8'd1;
                    end
                end
            end
            SHOW: begin
                // A button edge beats a coincident frame tick; fcnt stays put.
                if (btn_rise) begin
                    state_nxt   = PLAY;
                    restart_nxt = 1'b1;
                end else if (bus.frame_tick) begin
                    if (fcnt == BLINK_LAST) begin
                        blink_vis_nxt = ~blink_vis;
                        fcnt_nxt      = 8'd0;
                    end else begin
                        fcnt_nxt = fcnt + 8'd1;
                    end
                end
            end
            default: state_nxt = PLAY;
        endcase
    end

    // Pixel uses the current state, not the transition decided this cycle.
    always_comb begin
`ifdef END_SCREEN_DIM_EN
        if (state == PLAY)
            bg = bus.game_rgb;
        else
            bg = {1'b0, bus.game_rgb[11:9], 1'b0, bus.game_rgb[7:5], 1'b0, bus.game_rgb[3:1]};
`else
        bg = bus.game_rgb;
`endif
        if (!bus.video_on)
            rgb_nxt = 12'h000;
        else if (state == SHOW && blink_vis && bus.gameover_on)
            rgb_nxt = bus.gameover_rgb;
        else
            rgb_nxt = bg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            fcnt      <= 8'd0;
            blink_vis <= 1'b1;
            go_prev   <= 1'b0;
            btn_prev  <= 1'b0;
            rgb_q     <= 12'h000;
            freeze_q  <= 1'b0;
            restart_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            fcnt      <= fcnt_nxt;
            blink_vis <= blink_vis_nxt;
            go_prev   <= bus.game_over;
            btn_prev  <= bus.restart_btn;
            rgb_q     <= rgb_nxt;
            freeze_q  <= (state_nxt != PLAY);
            restart_q <= restart_nxt;
        end
    end

    assign bus.rgb_out     = rgb_q;
    assign bus.freeze      = freeze_q;
    assign bus.restart_req = restart_q;
endmodule
